// File: rtl/dmem_controller_if.sv
// Request/response bundle between the LSU (master) and the byte-addressable data memory (slave).
interface dmem_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_controller.sv
// Byte-addressable data memory: one load/store at a time, funct3 width decode,
// sign/zero-extended loads, lane-masked stores, error flagging and optional wait states.
module dmem_controller #(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] INIT_PATTERN = 32'hAAAA_AAAA
) (
  input logic              clk,
  input logic              rst_n,
  dmem_controller_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic          accept;
  logic          do_access;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          misaligned;
  logic          illegal;
  logic          err;

  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wdata_al;

  logic [31:0]   rsp_rdata_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;

  // Contents are preloaded rather than reset so that data survives rst_n.
  logic [31:0]   mem [DEPTH_WORDS] = '{default: INIT_PATTERN};

  assign bus.req_ready = (state == IDLE) && rst_n;
  assign accept        = bus.req_ready && bus.req_valid;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  assign idx  = addr_q[AW+1:2];
  assign lane = addr_q[1:0];

  always_comb begin
    out_of_range = |addr_q[31:AW+2];
    misaligned   = ((f3_q[1:0] == 2'b01) && lane[0]) ||
                   ((f3_q == 3'b010) && (lane != 2'b00));
    if (we_q) begin
      illegal = !((f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010));
    end else begin
      illegal = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
    end
    err = out_of_range || misaligned || illegal;
  end

  // Load path: pick the addressed byte/half, then extend according to funct3.
  always_comb begin
    rd_word   = mem[idx];
    rd_byte   = rd_word[8*lane +: 8];
    rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (f3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = '0;
    endcase
  end

  // Store path: replicate the right-aligned data across lanes and enable only the addressed ones.
  always_comb begin
    be       = 4'b0000;
    wdata_al = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be       = 4'b0001 << lane;
        wdata_al = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be       = 4'b1111;
        wdata_al = wdata_q;
      end
      default: begin
        be       = 4'b0000;
        wdata_al = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_access && rst_n && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= do_access;
      if (do_access) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (we_q || err) ? 32'd0 : load_data;
      end
    end
  end
endmodule

// File: tb/tb_dmem_controller.sv
// Scoreboard bench for dmem_controller: directed loads/stores, error cases, wait-state timing
// on a second instance, and reset landing on the write edge.
module tb_dmem_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dmem_controller_if bus0 ();
  dmem_controller_if bus1 ();

  dmem_controller #(.DEPTH_WORDS(256), .WAIT_STATES(0), .INIT_PATTERN(32'hAAAA_AAAA)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.slave)
  );

  dmem_controller #(.DEPTH_WORDS(256), .WAIT_STATES(3), .INIT_PATTERN(32'hAAAA_AAAA)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: every response pulse from dut0 is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus0.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h expected no response",
                 bus0.rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_rdata"}, bus0.rsp_rdata, mon_e.rdata);
        checkOutput({mon_e.name, "_err"}, {31'd0, bus0.rsp_err}, {31'd0, mon_e.err});
        checkOutput({mon_e.name, "_cycle"}, cyc, mon_e.due);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input string name);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (bus0.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus0.req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_ready_timeout: got req_ready=%b expected 1", name, bus0.req_ready);
      return;
    end
    bus0.req_valid  = 1'b1;
    bus0.req_we     = we;
    bus0.req_funct3 = f3;
    bus0.req_addr   = addr;
    bus0.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.due   = cyc + 1;
    e.name  = name;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [10:0] rdy_pat;
    logic [10:0] vld_pat;
    int          n;

    rst_n = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'b0;
    bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'b0;
    bus1.req_addr = '0; bus1.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'd0, bus0.req_ready}, 32'd0);
    checkOutput("rst_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    checkOutput("rst_rdata", bus0.rsp_rdata, 32'd0);
    checkOutput("rst_err",   {31'd0, bus0.rsp_err}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'hAAAA_AAAA, 1'b0, "lw_init");
    applyStimulus(1'b1, 3'b010, 32'h20, 32'h8765_4321, 32'h0, 1'b0, "sw_20");
    applyStimulus(1'b0, 3'b000, 32'h21, 32'h0, 32'h0000_0043, 1'b0, "lb_21");
    applyStimulus(1'b0, 3'b100, 32'h23, 32'h0, 32'h0000_0087, 1'b0, "lbu_23");
    applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_8765, 1'b0, "lh_22");
    applyStimulus(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_8765, 1'b0, "lhu_22");

    applyStimulus(1'b1, 3'b010, 32'h40, 32'h1122_3344, 32'h0, 1'b0, "sw_40");
    applyStimulus(1'b1, 3'b000, 32'h41, 32'h1234_56FF, 32'h0, 1'b0, "sb_41");
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 32'h1122_FF44, 1'b0, "lw_40_after_sb");
    applyStimulus(1'b1, 3'b001, 32'h42, 32'h5555_BEEF, 32'h0, 1'b0, "sh_42");
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 32'hBEEF_FF44, 1'b0, "lw_40_after_sh");

    applyStimulus(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, "lw_misaligned");
    applyStimulus(1'b0, 3'b010, 32'h00, 32'h0, 32'hAAAA_AAAA, 1'b0, "lw_00_reread");
    applyStimulus(1'b1, 3'b001, 32'h05, 32'h0000_BEEF, 32'h0, 1'b1, "sh_misaligned");
    applyStimulus(1'b0, 3'b010, 32'h04, 32'h0, 32'hAAAA_AAAA, 1'b0, "lw_04_reread");
    applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, "lw_out_of_range");
    applyStimulus(1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF, 32'h0, 1'b1, "sw_out_of_range");
    applyStimulus(1'b0, 3'b010, 32'h00, 32'h0, 32'hAAAA_AAAA, 1'b0, "lw_00_alias_check");
    applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, "load_illegal_f3");
    applyStimulus(1'b1, 3'b100, 32'h20, 32'h0000_0011, 32'h0, 1'b1, "store_illegal_f3");
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 32'h8765_4321, 1'b0, "lw_20_reread");

    // Second instance, three wait states: hold req_valid and watch ready/valid per cycle.
    rdy_pat = 11'b000_0010_0000;
    vld_pat = 11'b100_0001_0000;
    n = 0;
    @(negedge clk);
    while (bus1.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ws3_ready_initial", {31'd0, bus1.req_ready}, 32'd1);
    bus1.req_valid  = 1'b1;
    bus1.req_we     = 1'b0;
    bus1.req_funct3 = 3'b010;
    bus1.req_addr   = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 7) bus1.req_valid = 1'b0;
      checkOutput($sformatf("ws3_ready_k%0d", k), {31'd0, bus1.req_ready}, {31'd0, rdy_pat[k-1]});
      checkOutput($sformatf("ws3_valid_k%0d", k), {31'd0, bus1.rsp_valid}, {31'd0, vld_pat[k-1]});
      if (vld_pat[k-1]) begin
        checkOutput($sformatf("ws3_rdata_k%0d", k), bus1.rsp_rdata, 32'hAAAA_AAAA);
      end
    end

    // Reset asserted so that it lands on the write edge of a store: no response, no write.
    n = 0;
    @(negedge clk);
    while (bus0.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus0.req_valid  = 1'b1;
    bus0.req_we     = 1'b1;
    bus0.req_funct3 = 3'b010;
    bus0.req_addr   = 32'h20;
    bus0.req_wdata  = 32'h5555_5555;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", {31'd0, bus0.req_ready}, 32'd1);
    checkOutput("post_rst_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    checkOutput("post_rst_rdata", bus0.rsp_rdata, 32'd0);
    checkOutput("post_rst_err",   {31'd0, bus0.rsp_err}, 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 32'h8765_4321, 1'b0, "lw_20_after_rst");
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 32'hBEEF_FF44, 1'b0, "lw_40_survives_rst");

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
